// File: rtl/panel_seq.sv
// -----------------------------------------------------------------------------
// panel_seq -- front-panel sequencer for the Q2 machine.
//
// Debounces the six panel buttons, then runs the run/stop/single-step state
// machine. Deposit, load-address and increment-address operations act on the
// panel address register. Deposits use a mem_we/mem_ack handshake.
//
// Parameters
//   AW        panel address width (RAM + field bit), must be >= DW
//   DW        data/switch width
//   DEBOUNCE  stable cycles before a button change is accepted (>= 2)
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   nsw        data switches, active-low
//   nstart_sw  start button, active-low
//   nstop_sw   stop button, active-low
//   nstep_sw   single-step button, active-low
//   ndep_sw    deposit button, active-low
//   nincp_sw   increment-address button, active-low
//   nload_sw   load-address button, active-low
//   halt_in    core detected "jmp $" (level)
//   cyc_done   core finished an instruction (1-cycle pulse)
//   mem_ack    memory accepted the pending write
//   run        core running (RUN state)
//   core_en    core may execute (RUN or STEP)
//   pc_load    1-cycle pulse: core loads its PC from pc_value
//   pc_value   panel address register
//   mem_we     deposit write request, held until mem_ack
//   mem_wdata  switch value captured when deposit was pressed
//   halted     sticky: the last stop was caused by halt_in
// -----------------------------------------------------------------------------
module panel_seq #(
  parameter int AW       = 13,
  parameter int DW       = 12,
  parameter int DEBOUNCE = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] nsw,
  input  logic          nstart_sw,
  input  logic          nstop_sw,
  input  logic          nstep_sw,
  input  logic          ndep_sw,
  input  logic          nincp_sw,
  input  logic          nload_sw,
  input  logic          halt_in,
  input  logic          cyc_done,
  input  logic          mem_ack,
  output logic          run,
  output logic          core_en,
  output logic          pc_load,
  output logic [AW-1:0] pc_value,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          halted
);

  // Button indices inside the debounce vectors.
  localparam int NB      = 6;
  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_STEP  = 2;
  localparam int B_DEP   = 3;
  localparam int B_INCP  = 4;
  localparam int B_LOAD  = 5;

  // The counter only needs to reach DEBOUNCE-1.
  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [AW-1:0] PC_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DEP  = 2'd3
  } state_t;

  // Zero-extend a switch word to the panel address width.
  function automatic logic [AW-1:0] widen(input logic [DW-1:0] d);
    logic [AW-1:0] w;
    w = {AW{1'b0}};
    for (int b = 0; b < DW; b++) begin
      w[b] = d[b];
    end
    return w;
  endfunction

  logic [NB-1:0] btn_raw;     // active-high "pressed", unsynchronised
  logic [NB-1:0] btn_sync1;
  logic [NB-1:0] btn_sync2;
  logic [NB-1:0] btn_state;   // debounced level
  logic [NB-1:0] btn_ev;      // 1-cycle accepted-press events
  logic [CW-1:0] btn_cnt [NB];
  logic [DW-1:0] sw_sync1;
  logic [DW-1:0] sw_sync2;    // switch value, already inverted to active-high
  state_t        state;

  assign btn_raw = {~nload_sw, ~nincp_sw, ~ndep_sw, ~nstep_sw, ~nstop_sw, ~nstart_sw};

  // Synchronise the data switches so captured values are never metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync1 <= {DW{1'b0}};
      sw_sync2 <= {DW{1'b0}};
    end else begin
      sw_sync1 <= ~nsw;
      sw_sync2 <= sw_sync1;
    end
  end

  // Synchronise and debounce the buttons. The counter runs while the
  // synchronised level disagrees with the debounced level; after DEBOUNCE
  // consecutive disagreeing samples the debounced level flips. Only the
  // released->pressed flip produces an event, so one press gives one event
  // and a new press needs DEBOUNCE released samples first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync1 <= {NB{1'b0}};
      btn_sync2 <= {NB{1'b0}};
      btn_state <= {NB{1'b0}};
      btn_ev    <= {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
        btn_cnt[i] <= CNT_ZERO;
      end
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
      for (int i = 0; i < NB; i++) begin
        btn_ev[i] <= 1'b0;
        if (btn_sync2[i] != btn_state[i]) begin
          if (btn_cnt[i] == CNT_LAST) begin
            btn_cnt[i]   <= CNT_ZERO;
            btn_state[i] <= btn_sync2[i];
            btn_ev[i]    <= btn_sync2[i];
          end else begin
            btn_cnt[i] <= btn_cnt[i] + CNT_ONE;
          end
        end else begin
          btn_cnt[i] <= CNT_ZERO;
        end
      end
    end
  end

  // Panel state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      run       <= 1'b0;
      core_en   <= 1'b0;
      pc_load   <= 1'b0;
      pc_value  <= PC_ZERO;
      mem_we    <= 1'b0;
      mem_wdata <= {DW{1'b0}};
      halted    <= 1'b0;
    end else begin
      pc_load <= 1'b0;
      case (state)
        S_IDLE: begin
          // The if-chain order is the event priority; a stop event in IDLE
          // has no action of its own but still swallows everything below it.
          if (btn_ev[B_STOP]) begin
            state <= S_IDLE;
          end else if (btn_ev[B_START]) begin
            state   <= S_RUN;
            run     <= 1'b1;
            core_en <= 1'b1;
            pc_load <= 1'b1;
            halted  <= 1'b0;
          end else if (btn_ev[B_STEP]) begin
            state   <= S_STEP;
            core_en <= 1'b1;
            pc_load <= 1'b1;
          end else if (btn_ev[B_DEP]) begin
            state     <= S_DEP;
            mem_wdata <= sw_sync2;
            mem_we    <= 1'b1;
          end else if (btn_ev[B_LOAD]) begin
            pc_value <= widen(sw_sync2);
          end else if (btn_ev[B_INCP]) begin
            pc_value <= pc_value + PC_ONE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (btn_ev[B_STOP] || halt_in) begin
            state   <= S_IDLE;
            run     <= 1'b0;
            core_en <= 1'b0;
            halted  <= halt_in;
          end else begin
            state <= S_RUN;
          end
        end
        S_STEP: begin
          if (btn_ev[B_STOP] || halt_in) begin
            state   <= S_IDLE;
            core_en <= 1'b0;
            halted  <= halt_in;
          end else if (cyc_done) begin
            state   <= S_IDLE;
            core_en <= 1'b0;
          end else begin
            state <= S_STEP;
          end
        end
        S_DEP: begin
          // An ack coinciding with stop means memory already took the
          // write, so the address still advances past it.
          if (mem_ack) begin
            state    <= S_IDLE;
            mem_we   <= 1'b0;
            pc_value <= pc_value + PC_ONE;
          end else if (btn_ev[B_STOP]) begin
            state  <= S_IDLE;
            mem_we <= 1'b0;
          end else begin
            state <= S_DEP;
          end
        end
        default: begin
          state   <= S_IDLE;
          run     <= 1'b0;
          core_en <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_panel_seq.sv
// -----------------------------------------------------------------------------
// tb_panel_seq -- self-checking bench for panel_seq.
// Drives button presses as timed low pulses and keeps its own model of the
// panel address, the expected writes and the run/halted flags.
// -----------------------------------------------------------------------------
module tb_panel_seq;
  localparam int AW = 13;
  localparam int DW = 12;
  localparam int D  = 4;
  localparam int PC_MOD = 1 << AW;

  localparam logic [5:0] M_START = 6'b000001;
  localparam logic [5:0] M_STOP  = 6'b000010;
  localparam logic [5:0] M_STEP  = 6'b000100;
  localparam logic [5:0] M_DEP   = 6'b001000;
  localparam logic [5:0] M_INCP  = 6'b010000;
  localparam logic [5:0] M_LOAD  = 6'b100000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] nsw;
  logic [5:0]    btn;
  logic          halt_in, cyc_done, mem_ack;
  logic          run, core_en, pc_load, mem_we, halted;
  logic [AW-1:0] pc_value;
  logic [DW-1:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int pl_cnt = 0;
  int m_pc   = 0;
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];

  panel_seq #(.AW(AW), .DW(DW), .DEBOUNCE(D)) dut (
    .clk(clk), .rst(rst), .nsw(nsw),
    .nstart_sw(~btn[0]), .nstop_sw(~btn[1]), .nstep_sw(~btn[2]),
    .ndep_sw(~btn[3]), .nincp_sw(~btn[4]), .nload_sw(~btn[5]),
    .halt_in(halt_in), .cyc_done(cyc_done), .mem_ack(mem_ack),
    .run(run), .core_en(core_en), .pc_load(pc_load), .pc_value(pc_value),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .halted(halted)
  );

  always #5 clk = ~clk;

  // Count cycles with pc_load high.
  always @(posedge clk) begin
    #1;
    if (pc_load === 1'b1) pl_cnt++;
  end

  // Record every completed write handshake.
  always @(posedge clk) begin
    if (mem_we === 1'b1 && mem_ack === 1'b1) begin
      wr_addr.push_back(pc_value);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [5:0] m, input int hold);
    btn = m;
    tick(hold);
    btn = 6'b000000;
    tick(D + 4);
  endtask

  task automatic do_load(input int d);
    nsw = ~d[DW-1:0];
    tick(3);
    press(M_LOAD, D + 1);
    m_pc = d;
    chk("load_pc", pc_value, m_pc);
  endtask

  task automatic do_incp();
    press(M_INCP, D);
    m_pc = (m_pc + 1) % PC_MOD;
    chk("incp_pc", pc_value, m_pc);
  endtask

  task automatic do_dep(input int d);
    int w0;
    nsw = ~d[DW-1:0];
    tick(3);
    w0 = wr_addr.size();
    press(M_DEP, D + 1);
    for (int i = 0; i < 20 && mem_we !== 1'b1; i++) tick(1);
    chk("dep_we", mem_we, 1);
    chk("dep_data", mem_wdata, d);
    chk("dep_pc", pc_value, m_pc);
    nsw = ~($urandom_range(0, 4095) & 12'hFFF);
    tick(3);
    chk("dep_hold_data", mem_wdata, d);
    chk("dep_hold_we", mem_we, 1);
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    tick(1);
    chk("dep_we_drop", mem_we, 0);
    chk("dep_nwrites", wr_addr.size() - w0, 1);
    if (wr_addr.size() > w0) begin
      chk("dep_wr_addr", wr_addr[w0], m_pc);
      chk("dep_wr_data", wr_data[w0], d);
    end
    m_pc = (m_pc + 1) % PC_MOD;
    chk("dep_pc_inc", pc_value, m_pc);
  endtask

  initial begin
    int p0, w0, d;
    rst = 1'b1; btn = 6'b0; nsw = {DW{1'b1}};
    halt_in = 1'b0; cyc_done = 1'b0; mem_ack = 1'b0;
    tick(3);
    chk("rst_run", run, 0);
    chk("rst_core_en", core_en, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc_value", pc_value, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    tick(2);

    // Glitch shorter than the debounce window is rejected.
    p0 = pl_cnt;
    press(M_START, D - 1);
    chk("glitch_pl", pl_cnt - p0, 0);
    chk("glitch_run", run, 0);
    p0 = pl_cnt;
    press(M_START, D);
    chk("start_pl", pl_cnt - p0, 1);
    chk("start_run", run, 1);
    chk("start_core_en", core_en, 1);
    press(M_STOP, D + 2);
    chk("stop_run", run, 0);
    chk("stop_core_en", core_en, 0);
    chk("stop_halted", halted, 0);

    // Long hold gives only one event.
    p0 = pl_cnt;
    press(M_STEP, 6 * D);
    chk("long_step_pl", pl_cnt - p0, 1);
    cyc_done = 1'b1; tick(1); cyc_done = 1'b0; tick(1);
    chk("long_step_end", core_en, 0);

    for (int k = 0; k < 4; k++) do_load($urandom_range(0, 4095));
    for (int k = 0; k < 3; k++) do_incp();
    for (int k = 0; k < 3; k++) do_dep($urandom_range(0, 4095));

    // Directed deposit pair.
    w0 = wr_addr.size();
    do_load(0);
    do_dep(12'h123);
    do_dep(12'h456);
    chk("dep2_pc", pc_value, 2);
    chk("dep2_count", wr_addr.size() - w0, 2);

    // Address wrap.
    do_load(12'hFFF);
    do_incp();
    chk("wrap_1000", pc_value, 13'h1000);
    do_incp();
    chk("wrap_1001", pc_value, 13'h1001);
    for (int k = 0; k < 4094; k++) begin
      press(M_INCP, D);
      m_pc = (m_pc + 1) % PC_MOD;
    end
    chk("wrap_1fff", pc_value, 13'h1FFF);
    do_dep($urandom_range(0, 4095));
    chk("wrap_zero", pc_value, 0);

    // Run then halt.
    p0 = pl_cnt;
    press(M_START, D);
    chk("run2_pl", pl_cnt - p0, 1);
    tick(10);
    halt_in = 1'b1;
    tick(2);
    chk("halt_run", run, 0);
    chk("halt_core_en", core_en, 0);
    chk("halt_halted", halted, 1);
    halt_in = 1'b0;
    tick(2);
    p0 = pl_cnt;
    press(M_START, D);
    chk("restart_halted", halted, 0);
    chk("restart_pl", pl_cnt - p0, 1);
    chk("restart_run", run, 1);

    // RUN ignores panel edits, step and mem_ack.
    p0 = pl_cnt;
    nsw = ~(m_pc[DW-1:0] ^ 12'h5A5);
    tick(3);
    press(M_LOAD, D + 1);
    chk("run_load_ign", pc_value, m_pc);
    press(M_INCP, D + 1);
    chk("run_incp_ign", pc_value, m_pc);
    press(M_DEP, D + 1);
    chk("run_dep_ign", mem_we, 0);
    press(M_STEP, D + 1);
    chk("run_step_ign", pl_cnt - p0, 0);
    mem_ack = 1'b1; tick(1); mem_ack = 1'b0; tick(1);
    chk("run_ack_ign", pc_value, m_pc);
    chk("run_still", run, 1);
    press(M_STOP, D + 1);
    chk("run_stopped", run, 0);

    // Stop and start together in IDLE: stop wins.
    p0 = pl_cnt;
    press(M_START | M_STOP, D + 1);
    chk("coll_run", run, 0);
    chk("coll_pl", pl_cnt - p0, 0);

    // Single step.
    p0 = pl_cnt;
    press(M_STEP, D);
    chk("step_pl", pl_cnt - p0, 1);
    chk("step_core_en", core_en, 1);
    chk("step_run", run, 0);
    tick(5);
    chk("step_wait_en", core_en, 1);
    cyc_done = 1'b1;
    chk("step_done_cycle_en", core_en, 1);
    tick(1);
    cyc_done = 1'b0;
    chk("step_after_en", core_en, 0);
    tick(1);
    chk("step_idle_en", core_en, 0);
    do_load($urandom_range(0, 4095));

    // Step aborted by stop, and by halt.
    press(M_STEP, D);
    press(M_STOP, D + 1);
    chk("step_stop_en", core_en, 0);
    press(M_STEP, D);
    halt_in = 1'b1; tick(2); halt_in = 1'b0;
    chk("step_halt_en", core_en, 0);
    chk("step_halt_halted", halted, 1);

    // cyc_done and mem_ack in IDLE are ignored.
    cyc_done = 1'b1; tick(1); cyc_done = 1'b0; tick(1);
    chk("idle_cyc_done", core_en, 0);
    mem_ack = 1'b1; tick(1); mem_ack = 1'b0; tick(1);
    chk("idle_ack_pc", pc_value, m_pc);

    // Stop aborts a deposit.
    d = $urandom_range(0, 4095);
    nsw = ~d[DW-1:0];
    tick(3);
    w0 = wr_addr.size();
    press(M_DEP, D + 1);
    chk("abort_we_pre", mem_we, 1);
    press(M_STOP, D + 1);
    chk("abort_we", mem_we, 0);
    chk("abort_pc", pc_value, m_pc);
    mem_ack = 1'b1; tick(1); mem_ack = 1'b0; tick(1);
    chk("abort_ack_pc", pc_value, m_pc);
    chk("abort_nwrites", wr_addr.size() - w0, 0);

    // Asynchronous reset during a deposit and during a step.
    press(M_DEP, D + 1);
    chk("rstdep_we_pre", mem_we, 1);
    #1 rst = 1'b1;
    #1;
    chk("rstdep_we", mem_we, 0);
    chk("rstdep_pc", pc_value, 0);
    tick(2);
    rst = 1'b0;
    m_pc = 0;
    tick(2);
    press(M_STEP, D);
    chk("rststep_en_pre", core_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("rststep_en", core_en, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
